dp_result_checker: RTL

Self-checking consumer stage that sits directly downstream of the `MAIN` datapath (ADD/SUB/MUL/DIV/MOD/SHL/SHR/REG outputs) in the bench and lab bring-up harness. The stimulus side pushes golden values into an internal expected-value FIFO; each `res_valid` from the datapath pops one entry and compares it against `res_data`. Pass/fail counts, sticky error flags and a run-complete indication are reported. This replaces manual waveform inspection of datapath results.

---
 rtl/dp_result_checker.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dp_result_checker.sv
// Self-checking consumer for datapath results: golden values queue in a FIFO and each result pops one to compare.
// Optional DP_CHECKER_FIRST_BAD_EN captures the expected/received pair of the first mismatch after start.
module dp_result_checker #(
    parameter int DATAWIDTH  = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_CHECKS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    exp_push,
    input  logic [DATAWIDTH-1:0]    exp_data,
    input  logic                    res_valid,
    input  logic [DATAWIDTH-1:0]    res_data,
    output logic                    exp_full,
    output logic                    exp_empty,
    output logic [$clog2(DEPTH):0]  exp_count,
    output logic [15:0]             pass_cnt,
    output logic [15:0]             fail_cnt,
    output logic                    mismatch,
    output logic                    error,
    output logic                    underflow,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done,
    output logic [DATAWIDTH-1:0]    first_bad_exp,
    output logic [DATAWIDTH-1:0]    first_bad_got
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic [15:0]          pass_q, pass_d;
    logic [15:0]          fail_q, fail_d;
    logic                 mismatch_q, mismatch_d;
    logic                 error_q, error_d;
    logic                 underflow_q, underflow_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [16:0]          total;

    logic                 accept_start, check, is_empty, is_full;
    logic                 do_pop, do_push, drop, hit, miss, uflow;
    logic [DATAWIDTH-1:0] head;

    assign head         = mem_q[rd_ptr_q];
    assign is_empty     = (count_q == '0);
    assign is_full      = (count_q == CW'(DEPTH));
    assign accept_start = start && (state_q != S_RUN);
    assign check        = res_valid && (state_q == S_RUN);
    assign do_pop       = check && !is_empty;
    assign uflow        = check && is_empty;
    assign hit          = do_pop && (head == res_data);
    assign miss         = do_pop && (head != res_data);
    // A pop in the same cycle frees the slot, so a push on a full FIFO survives.
    assign do_push      = exp_push && (!is_full || do_pop);
    assign drop         = exp_push && is_full && !do_pop;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        mismatch_d  = 1'b0;
        error_d     = error_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        total       = '0;

        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    pass_d      = '0;
                    fail_d      = '0;
                    error_d     = 1'b0;
                    underflow_d = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (hit) pass_d = sat_inc(pass_q);
                if (miss || uflow) begin
                    fail_d  = sat_inc(fail_q);
                    error_d = 1'b1;
                end
                if (miss)  mismatch_d  = 1'b1;
                if (uflow) underflow_d = 1'b1;
                total = {1'b0, pass_d} + {1'b0, fail_d};
                if (check && (total >= 17'(NUM_CHECKS))) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Overflow is recorded in every state, after any start-clear in the same cycle.
        if (drop) overflow_d = 1'b1;

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pass_q      <= '0;
            fail_q      <= '0;
            mismatch_q  <= 1'b0;
            error_q     <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            mismatch_q  <= mismatch_d;
            error_q     <= error_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= exp_data;
    end

`ifdef DP_CHECKER_FIRST_BAD_EN
    logic                 fb_vld_q;
    logic [DATAWIDTH-1:0] fb_exp_q, fb_got_q;

    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            fb_vld_q <= 1'b0;
            fb_exp_q <= '0;
            fb_got_q <= '0;
        end else if (miss && !fb_vld_q) begin
            fb_vld_q <= 1'b1;
            fb_exp_q <= head;
            fb_got_q <= res_data;
        end
    end

    assign first_bad_exp = fb_exp_q;
    assign first_bad_got = fb_got_q;
`else
    assign first_bad_exp = '0;
    assign first_bad_got = '0;
`endif

    assign exp_full  = full_q;
    assign exp_empty = empty_q;
    assign exp_count = count_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign mismatch  = mismatch_q;
    assign error     = error_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
